// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - bounded up/down count-run controller
// Runs from a latched start value to a latched end value, with one-shot or auto-reload, hold and abort.
module counter_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic             dir,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] end_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] q_next;
  logic             tc_next;
  logic             capture;

  logic             dir_l;
  logic             reload_l;
  logic [WIDTH-1:0] start_l;
  logic [WIDTH-1:0] end_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      q        <= '0;
      tc       <= 1'b0;
      dir_l    <= 1'b0;
      reload_l <= 1'b0;
      start_l  <= '0;
      end_l    <= '0;
    end else begin
      state <= state_next;
      q     <= q_next;
      tc    <= tc_next;
      if (capture) begin
        dir_l    <= dir;
        reload_l <= auto_reload;
        start_l  <= start_val;
        end_l    <= end_val;
      end
    end
  end

  always_comb begin
    state_next = state;
    q_next     = q;
    tc_next    = 1'b0;
    capture    = 1'b0;
    // abort wins everywhere and always parks the count at zero
    if (abort) begin
      state_next = ST_IDLE;
      q_next     = '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            capture    = 1'b1;
            q_next     = start_val;
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (hold) begin
            state_next = ST_HOLD;
          end else if (q == end_l) begin
            tc_next = 1'b1;
            if (reload_l) q_next = start_l;
            else          state_next = ST_DONE;
          end else begin
            q_next = dir_l ? q + WIDTH'(1) : q - WIDTH'(1);
          end
        end
        ST_HOLD: begin
          if (!hold) state_next = ST_RUN;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_HOLD);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - scoreboard bench for counter_sequencer
// A run model tracks steps taken against the run span; a monitor compares every cycle.
module tb_counter_sequencer;

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_HOLD = 2;
  localparam int P_DONE = 3;

  logic       clk = 1'b0;
  logic       rst, start, abort, hold, dir, auto_reload;
  logic [3:0] start_val, end_val;
  logic [3:0] q;
  logic       tc, busy, done;

  counter_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
    .dir(dir), .auto_reload(auto_reload), .start_val(start_val), .end_val(end_val),
    .q(q), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] q;
    logic       tc;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // run model: a run is "span" steps from the start value, position = steps taken
  int ph = P_IDLE;
  int cur = 0;
  int steps = 0;
  int span = 0;
  int m_start = 0;
  bit m_dir = 0;
  bit m_ar = 0;
  bit m_tc = 0;

  task automatic model_step();
    m_tc = 0;
    if (rst) begin
      ph = P_IDLE; cur = 0; steps = 0; span = 0; m_start = 0; m_dir = 0; m_ar = 0;
    end else if (abort) begin
      ph = P_IDLE; cur = 0;
    end else begin
      if (ph == P_IDLE || ph == P_DONE) begin
        if (start) begin
          m_dir = dir; m_ar = auto_reload; m_start = int'(start_val);
          span = dir ? (int'(end_val) - int'(start_val) + 16) % 16
                     : (int'(start_val) - int'(end_val) + 16) % 16;
          steps = 0;
          ph = P_RUN;
        end
      end else if (ph == P_RUN) begin
        if (hold) ph = P_HOLD;
        else if (steps == span) begin
          m_tc = 1;
          if (m_ar) steps = 0;
          else      ph = P_DONE;
        end else steps++;
      end else if (!hold) begin
        ph = P_RUN;
      end
      if (ph != P_IDLE)
        cur = m_dir ? (m_start + steps) % 16 : (m_start - steps + 16) % 16;
    end
  endtask

  task automatic step();
    exp_t e;
    model_step();
    e.q = 4'(cur); e.tc = m_tc;
    e.busy = (ph == P_RUN || ph == P_HOLD);
    e.done = (ph == P_DONE);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ({q, tc, busy, done} !== e) begin
        errors++;
        $display("FAIL cycle_out t=%0t q/tc/busy/done got %0d/%0b/%0b/%0b want %0d/%0b/%0b/%0b",
                 $time, q, tc, busy, done, e.q, e.tc, e.busy, e.done);
      end
    end
  end

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // one run from a start pulse until done; returns the number of busy cycles
  task automatic run_one(input bit d, input logic [3:0] sv, input logic [3:0] ev,
                         input int hold_at, input bit inj, output int n);
    int hl;
    int k;
    dir = d; auto_reload = 0; start_val = sv; end_val = ev; start = 1;
    step();
    start = 0;
    n = 0; hl = 3; k = 0;
    while (!done && k < 80) begin
      if (busy) n++;
      hold = (hold_at >= 0 && cur == hold_at && hl > 0);
      if (hold) hl--;
      start = inj && (k == 2);
      if (start) begin
        dir = ~d; auto_reload = 1; start_val = sv + 4'd5; end_val = ev + 4'd3;
      end
      step();
      k++;
    end
    hold = 0; start = 0;
    if (k >= 80) begin
      errors++; checks++;
      $display("FAIL run_timeout got %0d cycles want done", k);
    end
  endtask

  initial begin
    int n;
    rst = 1; start = 0; abort = 0; hold = 0; dir = 0; auto_reload = 0;
    start_val = 0; end_val = 0;
    step(); step();
    rst = 0;
    step(); step();

    run_one(1, 4'd3, 4'd7, -1, 0, n);
    check_eq("len_up_3_7", n, ((7 - 3) & 15) + 1);
    step(); step();

    run_one(0, 4'd1, 4'd14, -1, 0, n);
    check_eq("len_down_wrap", n, ((1 - 14) & 15) + 1);

    run_one(1, 4'd0, 4'd9, 4, 0, n);
    check_eq("len_hold", n, 10 + 4);

    run_one(1, 4'd2, 4'd6, -1, 1, n);
    check_eq("len_start_ignored", n, 5);

    run_one(1, 4'd5, 4'd5, -1, 0, n);
    check_eq("len_equal", n, 1);

    abort = 1; start = 1; start_val = 4'd9; end_val = 4'd12;
    step();
    abort = 0; start = 0;
    check_eq("abort_beats_start_busy", int'(busy), 0);
    step(); step();

    dir = 1; auto_reload = 1; start_val = 0; end_val = 2; start = 1;
    step();
    start = 0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (tc) n++;
    end
    check_eq("reload_tc_count", n, 4);
    abort = 1; step(); abort = 0;

    dir = 1; auto_reload = 1; start_val = 7; end_val = 7; start = 1;
    step(); start = 0;
    for (int i = 0; i < 4; i++) step();

    start_val = 4'd10; end_val = 4'd3; dir = 0; auto_reload = 0;
    rst = 1; step(); step(); rst = 0;
    for (int i = 0; i < 4; i++) step();

    dir = 1; start_val = 4'd1; end_val = 4'd8; start = 1; step(); start = 0;
    step(); step();
    rst = 1; step(); step(); rst = 0;
    for (int i = 0; i < 3; i++) step();
    check_eq("reset_no_resume_q", int'(q), 0);

    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      start       = ($urandom_range(0, 7) == 0);
      abort       = ($urandom_range(0, 39) == 0);
      hold        = ($urandom_range(0, 4) == 0);
      dir         = 1'($urandom);
      auto_reload = ($urandom_range(0, 3) == 0);
      start_val   = 4'($urandom);
      end_val     = 4'($urandom);
      step();
    end
    rst = 0; start = 0; abort = 0; hold = 0;
    step();

    check_eq("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Run controller for a WIDTH-bit synchronous up/down counter: sequences one counting run from a programmed start value to a programmed end value, with one-shot or auto-reload behaviour, hold and abort. Sits between control logic and the counted datapath and replaces free-running counting with bounded, restartable runs. `q` is the counter value; `tc`, `busy` and `done` report run status.

## Interface
- `WIDTH`, default 4: counter width in bits; all count arithmetic is modulo 2^WIDTH.
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a run; honoured only in IDLE or DONE.
- `abort` in 1: end the current run and return to IDLE.
- `hold` in 1: level; freezes the count while high.
- `dir` in 1: 1 = up, 0 = down; sampled with `start`.
- `auto_reload` in 1: 1 = restart at start value after end value; sampled with `start`.
- `start_val` in WIDTH: first count value; sampled with `start`.
- `end_val` in WIDTH: terminal count value; sampled with `start`.
- `q` out WIDTH: current count, registered.
- `tc` out 1: one-cycle terminal-count pulse, registered.
- `busy` out 1: high in RUN and HOLD.
- `done` out 1: high in DONE.

## Operation
- States:
  - IDLE: nothing running.
  - RUN: counting.
  - HOLD: count frozen.
  - DONE: one-shot run finished.
- Reset (`rst`=1 at a clock edge):
  - state=IDLE, `q`=0, `tc`=0, `busy`=0, `done`=0.
  - Latched dir, auto_reload, start and end values = 0.
  - Reset overrides every other input, including mid-run.
- IDLE or DONE with `start`=1 and `abort`=0:
  - Latch `dir`, `auto_reload`, `start_val`, `end_val`.
  - `q` <= `start_val`; go to RUN.
- DONE with `abort`=1: go to IDLE. `abort` beats `start` in the same cycle.
- RUN, evaluated in priority order:
  1. `abort`: go to IDLE, `q` <= 0.
  2. `hold`: go to HOLD, `q` unchanged.
  3. `q` == latched end: `tc` <= 1.
     - auto_reload=1: `q` <= latched start, stay in RUN.
     - auto_reload=0: go to DONE, `q` unchanged.
  4. Otherwise: `q` <= `q`+1 (up) or `q`-1 (down), modulo 2^WIDTH. Wrap-around (15->0 up, 0->15 down) is legal within a run.
- HOLD:
  - `abort` has priority: go to IDLE, `q` <= 0.
  - `hold`=0: go to RUN, `q` unchanged. Counting resumes on the following edge.
- `start` in RUN or HOLD is ignored; latched config is unaffected.
- Input changes to `dir`, `auto_reload`, `start_val`, `end_val` outside a `start` capture have no effect.
- `start_val` == `end_val`: the first RUN cycle hits terminal count immediately.
  - One-shot: one RUN cycle.
  - Auto-reload: `tc` high every cycle, `q` constant.
- `tc` is 0 in every cycle not produced by rule 3; it never stays high for two cycles except in the equal-value auto-reload case.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- `start` sampled at edge N: `q`=`start_val` and `busy`=1 from cycle N+1.
- First increment or decrement is visible at N+2.
- One-shot run length, counting RUN cycles with no hold:
  - up: ((end−start) mod 2^WIDTH)+1
  - down: ((start−end) mod 2^WIDTH)+1
- At the terminal edge:
  - `tc`=1 for one cycle.
  - One-shot: `done`=1 and `busy`=0 in the same cycle as `tc`.
  - Auto-reload: `q`=start in the same cycle as `tc`.
- Hold:
  - `hold` high at edge M: `q` frozen from M+1.
  - `hold` low at edge K: state=RUN at K+1; next count change at K+2.
- `abort` at edge A: `q`=0, `busy`=0, `done`=0 at A+1.
- Restart from DONE: `start` at edge D gives `done`=0, `busy`=1, `q`=`start_val` at D+1.

## Test plan
- Reset values: assert `rst` for 2 cycles during an active run -> next cycle `q`=0, `tc`=0, `busy`=0, `done`=0, state IDLE; counting does not resume without `start`.
- One-shot up, WIDTH=4, start=3, end=7, `start` pulse at cycle 0 -> `q`=3,4,5,6,7 at cycles 1–5; cycle 6: `tc`=1, `done`=1, `busy`=0, `q`=7; cycle 7: `tc`=0.
- Down with wrap, start=1, end=14, dir=0 -> `q`=1,0,15,14, then `tc`=1 and `done`=1 with `q`=14.
- Auto-reload up, start=0, end=2 -> `q`=0,1,2,0,1,2,…; `tc` pulses exactly once per 3 cycles; `done` never asserts.
- Hold mid-run, start=0, end=9, `hold`=1 for 3 cycles when `q`=4 -> `q` stays 4 through HOLD plus one RUN cycle, then 5; `busy` stays 1; total run lengthens by 4 cycles.
- Priorities:
  - `abort` and `start` together in DONE -> IDLE, `q`=0.
  - `start` during RUN -> ignored; run completes with the original config.
  - start=end=5 one-shot -> `tc`=1 and `done`=1 two cycles after `start`.
